// File: rtl/tomasulo_rs_mcdb.sv
// Reservation station with multi-CDB wakeup, dispatch bypass, age-ordered issue,
// flush and occupancy count, feeding one execution unit over valid/ready.
module tomasulo_rs_mcdb #(
  parameter int unsigned RS_N    = 4,
  parameter int unsigned CDB_N   = 2,
  parameter int unsigned TAG_W   = 5,
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned ROBID_W = 5,
  parameter int unsigned REG_W   = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          disp_vld,
  output logic                          disp_rdy,
  input  logic [3:0]                    disp_op,
  input  logic [TAG_W-1:0]              disp_tag,
  input  logic [1:0]                    disp_busy,
  input  logic [2*WORD_W-1:0]           disp_opr,
  input  logic [ROBID_W-1:0]            disp_robid,
  input  logic [31:0]                   disp_imm,
  input  logic [REG_W-1:0]              disp_wa,
  input  logic [CDB_N-1:0]              cdb_vld,
  input  logic [CDB_N*TAG_W-1:0]        cdb_tag,
  input  logic [CDB_N*WORD_W-1:0]       cdb_wdata,
  output logic                          iss_vld,
  input  logic                          iss_rdy,
  output logic [3:0]                    iss_op,
  output logic [TAG_W-1:0]              iss_tag,
  output logic [31:0]                   iss_imm,
  output logic [ROBID_W-1:0]            iss_robid,
  output logic [REG_W-1:0]              iss_wa,
  output logic [2*WORD_W-1:0]           iss_rdata,
  output logic [$clog2(RS_N+1)-1:0]     occ,
  output logic                          cdb_err
);

  localparam int unsigned OCC_W = $clog2(RS_N + 1);

  typedef struct packed {
    logic              hit;
    logic [WORD_W-1:0] data;
  } cdb_hit_t;

  // Lowest-index valid bus carrying the tag wins.
  function automatic cdb_hit_t cdb_match(input logic [TAG_W-1:0]        t,
                                         input logic [CDB_N-1:0]        v,
                                         input logic [CDB_N*TAG_W-1:0]  tags,
                                         input logic [CDB_N*WORD_W-1:0] data);
    cdb_hit_t r;
    r.hit  = 1'b0;
    r.data = '0;
    for (int b = int'(CDB_N) - 1; b >= 0; b--) begin
      if (v[b] && (tags[b*TAG_W +: TAG_W] == t)) begin
        r.hit  = 1'b1;
        r.data = data[b*WORD_W +: WORD_W];
      end
    end
    return r;
  endfunction

  // Entry state
  logic [RS_N-1:0]    vld_q, vld_d;
  logic [3:0]         op_q    [RS_N];
  logic [3:0]         op_d    [RS_N];
  logic [TAG_W-1:0]   tag_q   [RS_N];
  logic [TAG_W-1:0]   tag_d   [RS_N];
  logic [1:0]         busy_q  [RS_N];
  logic [1:0]         busy_d  [RS_N];
  logic [WORD_W-1:0]  opr_q   [RS_N][2];
  logic [WORD_W-1:0]  opr_d   [RS_N][2];
  logic [ROBID_W-1:0] robid_q [RS_N];
  logic [ROBID_W-1:0] robid_d [RS_N];
  logic [31:0]        imm_q   [RS_N];
  logic [31:0]        imm_d   [RS_N];
  logic [REG_W-1:0]   wa_q    [RS_N];
  logic [REG_W-1:0]   wa_d    [RS_N];
  logic [RS_N-1:0]    age_q   [RS_N];
  logic [RS_N-1:0]    age_d   [RS_N];
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               cdb_err_q, cdb_err_d;

  logic [RS_N-1:0] ready, sel, alloc;
  logic            disp_acc, iss_acc, cdb_dup;
  cdb_hit_t        wake [RS_N][2];
  cdb_hit_t        byp  [2];

  assign disp_rdy = (occ_q != OCC_W'(RS_N));
  assign disp_acc = disp_vld && disp_rdy && !flush;
  assign iss_vld  = (|ready) && !flush;
  assign iss_acc  = iss_vld && iss_rdy;
  assign occ      = occ_q;
  assign cdb_err  = cdb_err_q;
  // Lowest clear bit of vld_q.
  assign alloc    = ~vld_q & (vld_q + RS_N'(1));

  always_comb begin
    for (int unsigned i = 0; i < RS_N; i++) begin
      for (int unsigned k = 0; k < 2; k++) begin
        wake[i][k] = cdb_match(opr_q[i][k][TAG_W-1:0], cdb_vld, cdb_tag, cdb_wdata);
      end
    end
    for (int unsigned k = 0; k < 2; k++) begin
      byp[k] = cdb_match(disp_opr[k*WORD_W +: TAG_W], cdb_vld, cdb_tag, cdb_wdata);
    end
  end

  always_comb begin
    cdb_dup = 1'b0;
    for (int unsigned a = 0; a < CDB_N; a++) begin
      for (int unsigned b = a + 1; b < CDB_N; b++) begin
        if (cdb_vld[a] && cdb_vld[b] &&
            (cdb_tag[a*TAG_W +: TAG_W] == cdb_tag[b*TAG_W +: TAG_W])) begin
          cdb_dup = 1'b1;
        end
      end
    end
  end

  // Oldest ready entry: ready with no older ready entry.
  always_comb begin
    ready = '0;
    sel   = '0;
    for (int unsigned i = 0; i < RS_N; i++) begin
      ready[i] = vld_q[i] && !busy_q[i][0] && !busy_q[i][1];
    end
    for (int unsigned i = 0; i < RS_N; i++) begin
      sel[i] = ready[i];
      for (int unsigned j = 0; j < RS_N; j++) begin
        if (ready[j] && age_q[j][i]) sel[i] = 1'b0;
      end
    end
  end

  always_comb begin
    iss_op    = '0;
    iss_tag   = '0;
    iss_imm   = '0;
    iss_robid = '0;
    iss_wa    = '0;
    iss_rdata = '0;
    for (int unsigned i = 0; i < RS_N; i++) begin
      if (sel[i]) begin
        iss_op    = op_q[i];
        iss_tag   = tag_q[i];
        iss_imm   = imm_q[i];
        iss_robid = robid_q[i];
        iss_wa    = wa_q[i];
        iss_rdata = {opr_q[i][1], opr_q[i][0]};
      end
    end
  end

  always_comb begin
    vld_d     = vld_q;
    op_d      = op_q;
    tag_d     = tag_q;
    busy_d    = busy_q;
    opr_d     = opr_q;
    robid_d   = robid_q;
    imm_d     = imm_q;
    wa_d      = wa_q;
    age_d     = age_q;
    cdb_err_d = cdb_err_q || cdb_dup;
    occ_d     = occ_q;

    for (int unsigned i = 0; i < RS_N; i++) begin
      for (int unsigned k = 0; k < 2; k++) begin
        if (vld_q[i] && busy_q[i][k] && wake[i][k].hit) begin
          opr_d[i][k]  = wake[i][k].data;
          busy_d[i][k] = 1'b0;
        end
      end
      if (iss_acc && sel[i]) vld_d[i] = 1'b0;
      if (disp_acc && alloc[i]) begin
        vld_d[i]   = 1'b1;
        op_d[i]    = disp_op;
        tag_d[i]   = disp_tag;
        robid_d[i] = disp_robid;
        imm_d[i]   = disp_imm;
        wa_d[i]    = disp_wa;
        for (int unsigned k = 0; k < 2; k++) begin
          if (disp_busy[k] && byp[k].hit) begin
            opr_d[i][k]  = byp[k].data;
            busy_d[i][k] = 1'b0;
          end else begin
            opr_d[i][k]  = disp_opr[k*WORD_W +: WORD_W];
            busy_d[i][k] = disp_busy[k];
          end
        end
        // New entry is younger than every currently valid entry.
        age_d[i] = '0;
        for (int unsigned j = 0; j < RS_N; j++) begin
          if (j != i) age_d[j][i] = vld_q[j];
        end
      end
    end

    if (disp_acc) occ_d = occ_d + OCC_W'(1);
    if (iss_acc)  occ_d = occ_d - OCC_W'(1);

    if (flush) begin
      vld_d = '0;
      occ_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q     <= '0;
      occ_q     <= '0;
      cdb_err_q <= 1'b0;
      for (int unsigned i = 0; i < RS_N; i++) begin
        op_q[i]    <= '0;
        tag_q[i]   <= '0;
        busy_q[i]  <= '0;
        opr_q[i][0] <= '0;
        opr_q[i][1] <= '0;
        robid_q[i] <= '0;
        imm_q[i]   <= '0;
        wa_q[i]    <= '0;
        age_q[i]   <= '0;
      end
    end else begin
      vld_q     <= vld_d;
      occ_q     <= occ_d;
      cdb_err_q <= cdb_err_d;
      op_q      <= op_d;
      tag_q     <= tag_d;
      busy_q    <= busy_d;
      opr_q     <= opr_d;
      robid_q   <= robid_d;
      imm_q     <= imm_d;
      wa_q      <= wa_d;
      age_q     <= age_d;
    end
  end

endmodule

// File: tb/tb_tomasulo_rs_mcdb.sv
// Directed bench for tomasulo_rs_mcdb: issue latency, wakeup, bypass, age order,
// full/backpressure, duplicate-CDB error, flush and asynchronous reset.
module tb_tomasulo_rs_mcdb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        disp_vld;
  logic        disp_rdy;
  logic [3:0]  disp_op;
  logic [4:0]  disp_tag;
  logic [1:0]  disp_busy;
  logic [63:0] disp_opr;
  logic [4:0]  disp_robid;
  logic [31:0] disp_imm;
  logic [4:0]  disp_wa;
  logic [1:0]  cdb_vld;
  logic [9:0]  cdb_tag;
  logic [63:0] cdb_wdata;
  logic        iss_vld;
  logic        iss_rdy;
  logic [3:0]  iss_op;
  logic [4:0]  iss_tag;
  logic [31:0] iss_imm;
  logic [4:0]  iss_robid;
  logic [4:0]  iss_wa;
  logic [63:0] iss_rdata;
  logic [2:0]  occ;
  logic        cdb_err;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tomasulo_rs_mcdb #(
    .RS_N(4), .CDB_N(2), .TAG_W(5), .WORD_W(32), .ROBID_W(5), .REG_W(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_vld(disp_vld), .disp_rdy(disp_rdy), .disp_op(disp_op), .disp_tag(disp_tag),
    .disp_busy(disp_busy), .disp_opr(disp_opr), .disp_robid(disp_robid),
    .disp_imm(disp_imm), .disp_wa(disp_wa),
    .cdb_vld(cdb_vld), .cdb_tag(cdb_tag), .cdb_wdata(cdb_wdata),
    .iss_vld(iss_vld), .iss_rdy(iss_rdy), .iss_op(iss_op), .iss_tag(iss_tag),
    .iss_imm(iss_imm), .iss_robid(iss_robid), .iss_wa(iss_wa), .iss_rdata(iss_rdata),
    .occ(occ), .cdb_err(cdb_err)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    flush     = 1'b0;
    disp_vld  = 1'b0;
    disp_op   = '0;
    disp_tag  = '0;
    disp_busy = '0;
    disp_opr  = '0;
    disp_robid = '0;
    disp_imm  = '0;
    disp_wa   = '0;
    cdb_vld   = '0;
    cdb_tag   = '0;
    cdb_wdata = '0;
  endtask

  task automatic disp(input logic [4:0] tag, input logic [1:0] busy,
                      input logic [31:0] o1, input logic [31:0] o0);
    disp_vld   = 1'b1;
    disp_op    = 4'h1;
    disp_tag   = tag;
    disp_busy  = busy;
    disp_opr   = {o1, o0};
    disp_robid = tag;
    disp_imm   = 32'h0;
    disp_wa    = 5'd0;
  endtask

  initial begin
    rst_n   = 1'b0;
    iss_rdy = 1'b0;
    idle();
    #1;
    chk("rst_occ", occ, 0);
    chk("rst_disp_rdy", disp_rdy, 1);
    chk("rst_iss_vld", iss_vld, 0);
    chk("rst_cdb_err", cdb_err, 0);
    chk("rst_rdata", iss_rdata, 0);
    #11 rst_n = 1'b1;
    tick();

    // Ready dispatch: one-cycle latency to issue.
    disp(5'd3, 2'b00, 32'd7, 32'd5);
    disp_robid = 5'd2;
    disp_imm   = 32'h100;
    disp_wa    = 5'd4;
    #1 chk("add_no_same_cycle", iss_vld, 0);
    tick();
    idle();
    #1;
    chk("add_iss_vld", iss_vld, 1);
    chk("add_iss_tag", iss_tag, 3);
    chk("add_rdata", iss_rdata, {32'd7, 32'd5});
    chk("add_op", iss_op, 1);
    chk("add_robid", iss_robid, 2);
    chk("add_imm", iss_imm, 32'h100);
    chk("add_wa", iss_wa, 4);
    chk("add_occ", occ, 1);
    iss_rdy = 1'b1;
    tick();
    iss_rdy = 1'b0;
    #1;
    chk("add_occ_after", occ, 0);
    chk("add_vld_after", iss_vld, 0);

    // Two waiters, woken out of order; older wins once both ready.
    disp(5'd1, 2'b01, 32'h11, 32'd9);
    tick();
    disp(5'd2, 2'b01, 32'h22, 32'd10);
    tick();
    idle();
    cdb_vld = 2'b01;
    cdb_tag = {5'd0, 5'd10};
    cdb_wdata = {32'h0, 32'hAA};
    #1;
    chk("wake_occ", occ, 2);
    chk("wake_no_same_cycle", iss_vld, 0);
    tick();
    cdb_vld = 2'b10;
    cdb_tag = {5'd9, 5'd0};
    cdb_wdata = {32'hBB, 32'h0};
    #1;
    chk("wake_t2_vld", iss_vld, 1);
    chk("wake_t2_tag", iss_tag, 2);
    chk("wake_t2_rdata", iss_rdata, {32'h22, 32'hAA});
    tick();
    idle();
    #1;
    chk("age_t1_tag", iss_tag, 1);
    chk("age_t1_rdata", iss_rdata, {32'h11, 32'hBB});
    iss_rdy = 1'b1;
    tick();
    #1;
    chk("age_then_t2", iss_tag, 2);
    chk("age_occ1", occ, 1);
    tick();
    iss_rdy = 1'b0;
    #1 chk("age_occ0", occ, 0);

    // Dispatch bypass from CDB1.
    disp(5'd7, 2'b01, 32'h66, 32'd4);
    cdb_vld = 2'b10;
    cdb_tag = {5'd4, 5'd0};
    cdb_wdata = {32'h55, 32'h0};
    #1 chk("byp_no_same_cycle", iss_vld, 0);
    tick();
    idle();
    #1;
    chk("byp_vld", iss_vld, 1);
    chk("byp_tag", iss_tag, 7);
    chk("byp_rdata", iss_rdata, {32'h66, 32'h55});
    iss_rdy = 1'b1;
    tick();
    iss_rdy = 1'b0;
    #1 chk("byp_occ", occ, 0);

    // Fill to full, release one slot, refill it with a younger entry.
    for (int t = 11; t <= 14; t++) begin
      disp(5'(t), 2'b00, 32'h0, 32'(t));
      tick();
    end
    disp(5'd15, 2'b00, 32'h0, 32'd15);
    iss_rdy = 1'b1;
    #1;
    chk("full_occ", occ, 4);
    chk("full_disp_rdy", disp_rdy, 0);
    chk("full_oldest", iss_tag, 11);
    tick();
    iss_rdy = 1'b0;
    #1;
    chk("freed_occ", occ, 3);
    chk("freed_disp_rdy", disp_rdy, 1);
    chk("freed_next", iss_tag, 12);
    tick();
    idle();
    #1;
    chk("refill_occ", occ, 4);
    chk("refill_disp_rdy", disp_rdy, 0);
    chk("refill_sel", iss_tag, 12);
    iss_rdy = 1'b1;
    for (int t = 12; t <= 15; t++) begin
      chk("drain_order", iss_tag, 64'(t));
      tick();
    end
    iss_rdy = 1'b0;
    #1 chk("drain_occ", occ, 0);

    // Dispatch and issue in the same cycle.
    disp(5'd20, 2'b00, 32'h0, 32'h20);
    tick();
    disp(5'd21, 2'b00, 32'h0, 32'h21);
    iss_rdy = 1'b1;
    #1 chk("sim_tag20", iss_tag, 20);
    tick();
    idle();
    #1;
    chk("sim_occ", occ, 1);
    chk("sim_tag21", iss_tag, 21);
    tick();
    iss_rdy = 1'b0;
    #1 chk("sim_occ0", occ, 0);

    // Same tag on both CDBs: bus 0 wins, error is sticky.
    disp(5'd8, 2'b01, 32'h77, 32'd6);
    tick();
    idle();
    cdb_vld = 2'b11;
    cdb_tag = {5'd6, 5'd6};
    cdb_wdata = {32'd2, 32'd1};
    #1 chk("dup_err_pre", cdb_err, 0);
    tick();
    idle();
    #1;
    chk("dup_err", cdb_err, 1);
    chk("dup_vld", iss_vld, 1);
    chk("dup_rdata", iss_rdata, {32'h77, 32'd1});
    iss_rdy = 1'b1;
    tick();
    iss_rdy = 1'b0;
    #1;
    chk("dup_err_sticky", cdb_err, 1);
    chk("dup_occ", occ, 0);

    // Flush with a concurrent dispatch.
    for (int t = 1; t <= 3; t++) begin
      disp(5'(t), 2'b00, 32'h0, 32'(t));
      tick();
    end
    idle();
    #1;
    chk("fl_occ3", occ, 3);
    chk("fl_vld_pre", iss_vld, 1);
    flush = 1'b1;
    disp(5'd4, 2'b00, 32'h0, 32'd4);
    iss_rdy = 1'b1;
    #1 chk("fl_vld_gated", iss_vld, 0);
    tick();
    idle();
    iss_rdy = 1'b0;
    #1;
    chk("fl_occ0", occ, 0);
    chk("fl_vld0", iss_vld, 0);
    tick();
    #1;
    chk("fl_no_alloc", iss_vld, 0);
    chk("fl_occ_stay", occ, 0);

    // Asynchronous reset while a wakeup is on the bus.
    disp(5'd5, 2'b00, 32'd1, 32'd2);
    tick();
    disp(5'd6, 2'b01, 32'h0, 32'd9);
    tick();
    idle();
    cdb_vld = 2'b01;
    cdb_tag = {5'd0, 5'd9};
    cdb_wdata = {32'h0, 32'h99};
    #1;
    chk("ar_occ_pre", occ, 2);
    chk("ar_tag_pre", iss_tag, 5);
    chk("ar_err_pre", cdb_err, 1);
    rst_n = 1'b0;
    #1;
    chk("ar_occ", occ, 0);
    chk("ar_vld", iss_vld, 0);
    chk("ar_disp_rdy", disp_rdy, 1);
    chk("ar_err", cdb_err, 0);
    chk("ar_tag", iss_tag, 0);
    chk("ar_rdata", iss_rdata, 0);
    idle();
    tick();
    rst_n = 1'b1;
    tick();
    #1;
    chk("ar_post_occ", occ, 0);
    chk("ar_post_vld", iss_vld, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
